// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit controller.
// Frame-level enums and the per-frame parity configuration bundle.
package uart_pkg;

  localparam int UART_WIDTH   = 8;
  localparam int UART_DEPTH   = 8;
  localparam int UART_BUSY_TO = 4;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } uart_tx_state_e;

  typedef struct packed {
    logic par_en;
    logic par_typ;
  } uart_cfg_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO feeding the UART transmit sequencer.
// Head word is visible combinationally on rdata while not empty.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = UART_WIDTH,
  parameter int DEPTH = UART_DEPTH,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rdata   = mem_q[rptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_ok) wptr_d = wptr_q + AW'(1);
    if (pop_ok)  rptr_d = rptr_q + AW'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: pointers alone define valid contents.
  always_ff @(posedge CLK) begin
    if (push_ok) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: buffers bytes and launches one frame
// at a time into the datapath using a valid pulse / busy handshake.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int WIDTH   = UART_WIDTH,
  parameter int DEPTH   = UART_DEPTH,
  parameter int BUSY_TO = UART_BUSY_TO,
  localparam int CW     = $clog2(DEPTH) + 1,
  localparam int TW     = $clog2(BUSY_TO + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             cfg_par_en,
  input  logic             cfg_par_typ,
  input  logic             clr_err,
  input  logic             tx_busy,
  output logic [WIDTH-1:0] tx_p_data,
  output logic             tx_data_valid,
  output logic             tx_par_en,
  output logic             tx_par_typ,
  output logic             fifo_full,
  output logic             fifo_empty,
  output logic [CW-1:0]    fifo_count,
  output logic             ctrl_idle,
  output logic             ovf_err,
  output logic             to_err
);

  uart_tx_state_e   state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  uart_cfg_t        cfg_q, cfg_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic             ovf_q, ovf_d;
  logic             to_q, to_d;
  logic             pop;
  logic             to_set;
  logic             ovf_set;
  logic [WIDTH-1:0] fifo_rdata;

  uart_tx_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (wr_en),
    .wdata (wr_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cfg_d   = cfg_q;
    tcnt_d  = tcnt_q;
    pop     = 1'b0;
    to_set  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty && !tx_busy) begin
          pop     = 1'b1;
          data_d  = fifo_rdata;
          cfg_d   = '{par_en: cfg_par_en, par_typ: cfg_par_typ};
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        tcnt_d  = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (tcnt_q == TW'(BUSY_TO - 1)) begin
          // Datapath never answered: drop the frame.
          to_set  = 1'b1;
          state_d = IDLE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A new error beats a simultaneous clear.
  assign ovf_set = wr_en && fifo_full;

  always_comb begin
    ovf_d = ovf_q;
    to_d  = to_q;
    if (clr_err) begin
      ovf_d = 1'b0;
      to_d  = 1'b0;
    end
    if (ovf_set) ovf_d = 1'b1;
    if (to_set)  to_d  = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      data_q  <= '0;
      cfg_q   <= '0;
      tcnt_q  <= '0;
      ovf_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cfg_q   <= cfg_d;
      tcnt_q  <= tcnt_d;
      ovf_q   <= ovf_d;
      to_q    <= to_d;
    end
  end

  assign tx_p_data     = data_q;
  assign tx_par_en     = cfg_q.par_en;
  assign tx_par_typ    = cfg_q.par_typ;
  assign tx_data_valid = (state_q == LAUNCH);
  assign ctrl_idle     = (state_q == IDLE) && fifo_empty;
  assign ovf_err       = ovf_q;
  assign to_err        = to_q;

endmodule
